// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline skid register.
//   skid_state_e : occupancy state of the two-entry skid stage
//   SKID_DEPTH   : number of payload slots held by the stage
//   skid_count() : maps an occupancy state onto the held-entry count
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam logic [1:0] SKID_DEPTH = 2'd2;

    // The state encoding is chosen so the count is simply the encoding, but
    // keep the mapping explicit so a re-encoding cannot silently break o_count.
    function automatic logic [1:0] skid_count(input skid_state_e st);
        logic [1:0] cnt;
        cnt = 2'd0;
        case (st)
            EMPTY:   cnt = 2'd0;
            ONE:     cnt = 2'd1;
            FULL:    cnt = SKID_DEPTH;
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/en_reg.sv
// -----------------------------------------------------------------------------
// en_reg
// WIDTH-bit storage register with write enable and synchronous clear.
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset, loads RESET_VALUE
//   i_clr  : synchronous clear to RESET_VALUE (wins over i_en)
//   i_en   : write enable, loads i_d
//   i_d    : data in
//   o_q    : registered data out
// -----------------------------------------------------------------------------
module en_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (i_clr) begin
            data_d = RESET_VALUE;
        end else if (i_en) begin
            data_d = i_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. Every output comes straight from a flop, so o_ready has no
// combinational dependence on i_ready and stages can be chained freely.
//   i_clk   : rising-edge clock
//   i_rst   : asynchronous active-high reset
//   i_flush : synchronous flush, discards all held entries
//   i_valid : upstream presents i_data
//   i_data  : upstream payload
//   o_ready : stage can accept a payload this cycle
//   o_valid : stage presents o_data downstream
//   o_data  : downstream payload (head of the two-entry FIFO)
//   i_ready : downstream accepts o_data this cycle
//   o_count : number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_count
);

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             valid_q;
    logic             valid_d;
    logic             ready_q;
    logic             ready_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;

    logic             in_fire;
    logic             out_fire;

    assign in_fire  = i_valid & ready_q;
    assign out_fire = valid_q & i_ready;

    // Next-state and data steering. main_q always holds the oldest entry;
    // skid_q only ever holds the second entry while FULL.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready_q is low here, so in_fire cannot occur.
                if (out_fire) begin
                    state_d        = ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush drops everything, including a same-cycle incoming payload;
        // a same-cycle out_fire has already been sampled downstream.
        if (i_flush) begin
            state_d = EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_q : i_data;

    // Outputs are precomputed from the next state so they leave flops.
    always_comb begin
        count_d = skid_count(state_d);
        valid_d = (state_d != EMPTY);
        ready_d = (count_d != SKID_DEPTH);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_en  (main_en),
        .i_d   (main_d),
        .o_q   (main_q)
    );

    en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_flush),
        .i_en  (skid_en),
        .i_d   (i_data),
        .o_q   (skid_q)
    );

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_count = count_q;
    assign o_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg (WIDTH = 8, RESET_VALUE = 8'h00).
// A queue-based FIFO model predicts outputs every cycle; directed scenarios
// add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         dut_ready;
    logic         dut_valid;
    logic [W-1:0] dut_data;
    logic [1:0]   dut_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_skid_reg #(
        .WIDTH       (W),
        .RESET_VALUE (8'h00)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .i_data  (in_data),
        .o_ready (dut_ready),
        .o_valid (dut_valid),
        .o_data  (dut_data),
        .i_ready (out_ready),
        .o_count (dut_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: a FIFO of at most two words --------
    logic [W-1:0] model_q[$];
    logic [W-1:0] model_hold;   // what o_data shows when nothing is held

    initial begin
        model_hold = 8'h00;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_q.delete();
                model_hold = 8'h00;
            end else begin
                automatic bit acc = in_valid && (model_q.size() < 2);
                automatic bit dlv = (model_q.size() > 0) && out_ready;
                if (flush) begin
                    model_q.delete();
                    model_hold = 8'h00;
                end else begin
                    if (dlv) void'(model_q.pop_front());
                    if (acc) model_q.push_back(in_data);
                end
                if (model_q.size() > 0) model_hold = model_q[0];
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_valid", 32'(dut_valid), 32'(model_q.size() > 0));
        check("cyc_ready", 32'(dut_ready), 32'(model_q.size() < 2));
        check("cyc_count", 32'(dut_count), 32'(model_q.size()));
        check("cyc_data",  32'(dut_data),  32'(model_q.size() > 0 ? model_q[0] : model_hold));
    end

    // ---------------- stimulus -----------------------------------------------
    // Called at posedge+2; applies inputs for one cycle and returns at the
    // next posedge+2, when registered outputs reflect that edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic rd,
                              input logic [1:0] c, input logic [W-1:0] d);
        check({tag, "_valid"}, 32'(dut_valid), 32'(v));
        check({tag, "_ready"}, 32'(dut_ready), 32'(rd));
        check({tag, "_count"}, 32'(dut_count), 32'(c));
        check({tag, "_data"},  32'(dut_data),  32'(d));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        expect_out("reset0", 1'b0, 1'b1, 2'd0, 8'h00);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Streaming
        cycle(1'b1, 8'h11, 1'b1, 1'b0); expect_out("stream11", 1'b1, 1'b1, 2'd1, 8'h11);
        cycle(1'b1, 8'h22, 1'b1, 1'b0); expect_out("stream22", 1'b1, 1'b1, 2'd1, 8'h22);
        cycle(1'b1, 8'h33, 1'b1, 1'b0); expect_out("stream33", 1'b1, 1'b1, 2'd1, 8'h33);
        cycle(1'b0, 8'h00, 1'b1, 1'b0); expect_out("streamend", 1'b0, 1'b1, 2'd0, 8'h33);

        // Backpressure
        cycle(1'b1, 8'hA1, 1'b0, 1'b0); expect_out("bp_a1", 1'b1, 1'b1, 2'd1, 8'hA1);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0); expect_out("bp_a2", 1'b1, 1'b0, 2'd2, 8'hA1);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0); expect_out("bp_a3rej", 1'b1, 1'b0, 2'd2, 8'hA1);
        cycle(1'b1, 8'hA3, 1'b1, 1'b0); expect_out("bp_drain1", 1'b1, 1'b1, 2'd1, 8'hA2);
        cycle(1'b1, 8'hA3, 1'b1, 1'b0); expect_out("bp_drain2", 1'b1, 1'b1, 2'd1, 8'hA3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0); expect_out("bp_empty", 1'b0, 1'b1, 2'd0, 8'hA3);

        // Flush colliding with in_fire and out_fire
        cycle(1'b1, 8'h55, 1'b0, 1'b0); expect_out("fc_55", 1'b1, 1'b1, 2'd1, 8'h55);
        cycle(1'b1, 8'h66, 1'b1, 1'b1); expect_out("fc_flush", 1'b0, 1'b1, 2'd0, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 1'b0); expect_out("fc_after", 1'b0, 1'b1, 2'd0, 8'h00);

        // Flush while FULL
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 8'h88, 1'b0, 1'b0); expect_out("ff_full", 1'b1, 1'b0, 2'd2, 8'h77);
        cycle(1'b0, 8'h00, 1'b0, 1'b1); expect_out("ff_flush", 1'b0, 1'b1, 2'd0, 8'h00);
        cycle(1'b1, 8'h99, 1'b0, 1'b0); expect_out("ff_99", 1'b1, 1'b1, 2'd1, 8'h99);
        cycle(1'b0, 8'h00, 1'b1, 1'b0); expect_out("ff_99gone", 1'b0, 1'b1, 2'd0, 8'h99);

        // Asynchronous reset while FULL
        cycle(1'b1, 8'hB1, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0); expect_out("rst_full", 1'b1, 1'b0, 2'd2, 8'hB1);
        rst = 1'b1;
        #1;
        expect_out("rst_async", 1'b0, 1'b1, 2'd0, 8'h00);
        @(posedge clk); @(posedge clk); #2;
        expect_out("rst_held", 1'b0, 1'b1, 2'd0, 8'h00);
        rst = 1'b0;
        cycle(1'b1, 8'hC3, 1'b1, 1'b0); expect_out("rst_resume", 1'b1, 1'b1, 2'd1, 8'hC3);

        // Random stress; upstream keeps a stalled payload stable
        begin
            logic         v;
            logic [W-1:0] d;
            logic         stall;
            stall = 1'b0;
            v     = 1'b0;
            d     = '0;
            for (int i = 0; i < 10000; i++) begin
                if (!stall) begin
                    v = ($urandom_range(99) < 70);
                    d = W'($urandom);
                end
                in_valid  = v;
                in_data   = d;
                out_ready = ($urandom_range(99) < 60);
                flush     = ($urandom_range(99) < 2);
                stall     = v && !dut_ready;
                @(posedge clk);
                #2;
            end
        end

        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("final_count", 32'(dut_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
